// File: rtl/adam_obi_pkg.sv
// Shared types and helpers for the OBI arbiter: pause FSM states and the
// round-robin pick function used by adam_obi_arbiter.
package adam_obi_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        PAUSED
    } arb_state_t;

    // Upper bound on the requester count the pick helper can search.
    localparam int unsigned PICK_MAX = 32;

    // First requesting index at or after ptr, wrapping modulo n.
    // valid is 0 when no index in [0, n) is requesting.
    function automatic int unsigned rr_pick(
        input  logic [PICK_MAX-1:0] req,
        input  int unsigned         n,
        input  int unsigned         ptr,
        output logic                valid
    );
        int unsigned idx;
        int unsigned k;
        valid = 1'b0;
        idx   = ptr;
        for (int unsigned i = 0; i < PICK_MAX; i++) begin
            if (i < n && !valid) begin
                k = ptr + i;
                if (k >= n) k = k - n;
                if (req[k]) begin
                    valid = 1'b1;
                    idx   = k;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/adam_obi_arbiter_idfifo.sv
// ID FIFO for the OBI arbiter: remembers which requester issued each
// outstanding transaction so in-order responses can be routed back.
module adam_obi_arbiter_idfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy tracking; cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adam_obi_arbiter.sv
// Shares one OBI master port between NO_SLVS requesters. Round-robin
// arbitration with OBI request locking, in-order response routing through an
// ID FIFO, and a pause/drain handshake.
// Optional: define ADAM_OBI_ARBITER_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no round-robin pointer).
module adam_obi_arbiter
    import adam_obi_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STRB_W    = DATA_W / 8,
    parameter int unsigned NO_SLVS   = 2,
    parameter int unsigned MAX_TRANS = 4,
    parameter int unsigned IDX_W     = (NO_SLVS > 1) ? $clog2(NO_SLVS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             pause_req,
    output logic                             pause_ack,

    input  logic [NO_SLVS-1:0]               slv_req,
    output logic [NO_SLVS-1:0]               slv_gnt,
    input  logic [NO_SLVS-1:0][ADDR_W-1:0]   slv_addr,
    input  logic [NO_SLVS-1:0]               slv_we,
    input  logic [NO_SLVS-1:0][STRB_W-1:0]   slv_be,
    input  logic [NO_SLVS-1:0][DATA_W-1:0]   slv_wdata,
    output logic [NO_SLVS-1:0]               slv_rvalid,
    output logic [NO_SLVS-1:0][DATA_W-1:0]   slv_rdata,

    output logic                             mst_req,
    input  logic                             mst_gnt,
    output logic [ADDR_W-1:0]                mst_addr,
    output logic                             mst_we,
    output logic [STRB_W-1:0]                mst_be,
    output logic [DATA_W-1:0]                mst_wdata,
    input  logic                             mst_rvalid,
    input  logic [DATA_W-1:0]                mst_rdata
);

    arb_state_t       state, state_d;
    logic             lock, lock_d;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] sel;
    logic             en;
    logic             hs;
    logic             rsp;
    logic             full;
    logic             empty;
    logic [IDX_W-1:0] head;
`ifndef ADAM_OBI_ARBITER_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;
`endif

    // Request selection, lock hold and muxing onto the shared port.
    always_comb begin
        pick_valid = 1'b0;
`ifdef ADAM_OBI_ARBITER_FIXED_PRIO_EN
        pick_idx = IDX_W'(rr_pick(PICK_MAX'(slv_req), NO_SLVS, 0, pick_valid));
`else
        pick_idx = IDX_W'(rr_pick(PICK_MAX'(slv_req), NO_SLVS, 32'(rr_ptr), pick_valid));
`endif
        sel       = lock ? lock_idx : pick_idx;
        en        = (state == RUN) && !full;
        mst_req   = en && (lock ? slv_req[lock_idx] : pick_valid);
        mst_addr  = slv_addr[sel];
        mst_we    = slv_we[sel];
        mst_be    = slv_be[sel];
        mst_wdata = slv_wdata[sel];
        hs        = mst_req && mst_gnt;
        lock_d    = lock;
        if (hs)           lock_d = 1'b0;
        else if (mst_req) lock_d = 1'b1;
        slv_gnt = '0;
        if (hs) slv_gnt[sel] = 1'b1;
    end

    // Route each response to the requester at the head of the ID FIFO.
    always_comb begin
        rsp        = mst_rvalid && !empty;
        slv_rvalid = '0;
        slv_rdata  = '0;
        for (int unsigned i = 0; i < NO_SLVS; i++) begin
            if (rsp && head == IDX_W'(i)) begin
                slv_rvalid[i] = 1'b1;
                slv_rdata[i]  = mst_rdata;
            end
        end
    end

    // Lock register: holds a requested-but-ungranted selection stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            lock <= lock_d;
            if (mst_req && !mst_gnt) lock_idx <= sel;
        end
    end

`ifndef ADAM_OBI_ARBITER_FIXED_PRIO_EN
    // Round-robin pointer advances past the index that just handshook.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (sel == IDX_W'(NO_SLVS - 1)) ? '0 : sel + IDX_W'(1);
        end
    end
`endif

    // Pause FSM state register; block comes out of reset paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PAUSED;
        else     state <= state_d;
    end

    // Pause FSM next state. Leaving RUN looks at the next lock value so a
    // request that is going unanswered this cycle is never withdrawn.
    always_comb begin
        state_d = state;
        case (state)
            RUN:     if (pause_req && !lock_d) state_d = DRAIN;
            DRAIN:   if (empty)                state_d = PAUSED;
            PAUSED:  if (!pause_req)           state_d = RUN;
            default:                           state_d = RUN;
        endcase
    end

    assign pause_ack = (state == PAUSED);

    adam_obi_arbiter_idfifo #(
        .DEPTH (MAX_TRANS),
        .WIDTH (IDX_W)
    ) u_idfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .pop   (rsp),
        .din   (sel),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_adam_obi_arbiter.sv
// Self-checking bench for adam_obi_arbiter (NO_SLVS=2, MAX_TRANS=4).
// Honours ADAM_OBI_ARBITER_FIXED_PRIO_EN for the expected grant order.
module tb_adam_obi_arbiter;

    localparam int N   = 2;
    localparam int MAX = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pause_req;
    logic                 pause_ack;
    logic [1:0]           slv_req;
    logic [1:0]           slv_gnt;
    logic [1:0][31:0]     slv_addr;
    logic [1:0]           slv_we;
    logic [1:0][3:0]      slv_be;
    logic [1:0][31:0]     slv_wdata;
    logic [1:0]           slv_rvalid;
    logic [1:0][31:0]     slv_rdata;
    logic                 mst_req;
    logic                 mst_gnt;
    logic [31:0]          mst_addr;
    logic                 mst_we;
    logic [3:0]           mst_be;
    logic [31:0]          mst_wdata;
    logic                 mst_rvalid;
    logic [31:0]          mst_rdata;

    adam_obi_arbiter #(
        .NO_SLVS   (N),
        .MAX_TRANS (MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause_req  (pause_req),
        .pause_ack  (pause_ack),
        .slv_req    (slv_req),
        .slv_gnt    (slv_gnt),
        .slv_addr   (slv_addr),
        .slv_we     (slv_we),
        .slv_be     (slv_be),
        .slv_wdata  (slv_wdata),
        .slv_rvalid (slv_rvalid),
        .slv_rdata  (slv_rdata),
        .mst_req    (mst_req),
        .mst_gnt    (mst_gnt),
        .mst_addr   (mst_addr),
        .mst_we     (mst_we),
        .mst_be     (mst_be),
        .mst_wdata  (mst_wdata),
        .mst_rvalid (mst_rvalid),
        .mst_rdata  (mst_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One directed cycle: drive at posedge+1, check at negedge, advance.
    task automatic cyc(input string tag, input logic [1:0] req, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic preq,
                       input logic e_req, input logic [1:0] e_gnt, input logic [1:0] e_rv,
                       input logic e_ack, input logic [31:0] e_addr);
        logic [1:0][31:0] e_rdata;
        slv_req    = req;
        mst_gnt    = gnt;
        mst_rvalid = rv;
        mst_rdata  = rd;
        pause_req  = preq;
        e_rdata[0] = e_rv[0] ? rd : 32'h0;
        e_rdata[1] = e_rv[1] ? rd : 32'h0;
        @(negedge clk);
        chk({tag, ".mst_req"}, mst_req, e_req);
        chk({tag, ".slv_gnt"}, slv_gnt, e_gnt);
        chk({tag, ".slv_rvalid"}, slv_rvalid, e_rv);
        chk({tag, ".slv_rdata"}, slv_rdata, e_rdata);
        chk({tag, ".pause_ack"}, pause_ack, e_ack);
        if (e_req) chk({tag, ".mst_addr"}, mst_addr, e_addr);
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase.
    int   q[$];
    int   m_ptr;
    bit   m_lock;
    int   m_lidx;

    initial begin
        logic [1:0] ga, gb;
`ifdef ADAM_OBI_ARBITER_FIXED_PRIO_EN
        ga = 2'b01; gb = 2'b01;
`else
        ga = 2'b10; gb = 2'b01;
`endif
        //            req    gnt   rv    rdata          e_req e_gnt  e_rv
        tbl[0]  = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00};
        tbl[1]  = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00};
        tbl[2]  = '{2'b00, 1'b0, 1'b1, 32'hCAFE0000, 1'b0, 2'b00, 2'b01};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, ga,    2'b00};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, gb,    2'b00};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, ga,    2'b00};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, gb,    2'b00};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00};
        tbl[8]  = '{2'b11, 1'b1, 1'b1, 32'h11111111, 1'b0, 2'b00, ga};
        tbl[9]  = '{2'b11, 1'b1, 1'b1, 32'h22222222, 1'b1, ga,    gb};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 32'h33333333, 1'b0, 2'b00, ga};
        tbl[11] = '{2'b00, 1'b0, 1'b1, 32'h44444444, 1'b0, 2'b00, gb};
        tbl[12] = '{2'b00, 1'b0, 1'b1, 32'h55555555, 1'b0, 2'b00, ga};
        tbl[13] = '{2'b00, 1'b0, 1'b1, 32'h66666666, 1'b0, 2'b00, 2'b00};

        rst        = 1'b1;
        pause_req  = 1'b0;
        slv_req    = '0;
        slv_addr[0] = 32'h1000;
        slv_addr[1] = 32'h2000;
        slv_we     = '0;
        slv_be     = '0;
        slv_wdata  = '0;
        mst_gnt    = 1'b0;
        mst_rvalid = 1'b0;
        mst_rdata  = '0;

        #2;
        chk("reset.pause_ack", pause_ack, 1'b1);
        chk("reset.mst_req", mst_req, 1'b0);
        chk("reset.slv_gnt", slv_gnt, 2'b00);
        chk("reset.slv_rvalid", slv_rvalid, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("run.pause_ack", pause_ack, 1'b0);

        // Basic grant/response, alternation, FIFO full and in-order return.
        for (int i = 0; i < 14; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata,
                1'b0, tbl[i].e_req, tbl[i].e_gnt, tbl[i].e_rv, 1'b0,
                tbl[i].e_gnt[1] ? 32'h2000 : 32'h1000);
        end

        // Lock: slv1 waits three cycles, slv0 joins, slv1 keeps the port.
        cyc("lock1", 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h2000);
        cyc("lock2", 2'b11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h2000);
        cyc("lock3", 2'b11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h2000);
        cyc("lock4", 2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 32'h2000);
        cyc("lock5", 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 32'h1000);

        // Pause with two outstanding (slv1 then slv0).
        cyc("pause1", 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        cyc("pause2", 2'b01, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        cyc("pause3", 2'b01, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0);
        cyc("pause4", 2'b01, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 32'h0);
        cyc("pause5", 2'b01, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        cyc("pause6", 2'b01, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
        cyc("pause7", 2'b01, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
        cyc("pause8", 2'b01, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 32'h1000);
        cyc("pause9", 2'b01, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 32'h1000);
        cyc("pause10", 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 32'h2000);

        // Reset mid-cycle with three outstanding.
        slv_req = 2'b00;
        mst_gnt = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst.pause_ack", pause_ack, 1'b1);
        chk("rst.mst_req", mst_req, 1'b0);
        mst_rvalid = 1'b1;
        mst_rdata  = 32'hDEADBEEF;
        #1;
        chk("rst.slv_rvalid", slv_rvalid, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("stray", 2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);

        // Random traffic against the queue-based reference model.
        q.delete();
        m_ptr  = 0;
        m_lock = 1'b0;
        m_lidx = 0;
        for (int c = 0; c < 2000; c++) begin
            int         sel;
            bit         found;
            bit         e_req;
            logic [1:0] e_gnt, e_rv;
            logic [1:0][31:0] e_rdata;
            for (int i = 0; i < N; i++) begin
                slv_req[i]   = ($urandom_range(0, 99) < 60);
                slv_addr[i]  = $urandom;
                slv_we[i]    = 1'($urandom_range(0, 1));
                slv_be[i]    = 4'($urandom_range(0, 15));
                slv_wdata[i] = $urandom;
            end
            if (m_lock) slv_req[m_lidx] = 1'b1;
            mst_gnt    = 1'($urandom_range(0, 1));
            mst_rvalid = ($urandom_range(0, 99) < 40);
            mst_rdata  = $urandom;
            pause_req  = 1'b0;

            found = 1'b0;
            sel   = 0;
            if (m_lock) begin
                sel   = m_lidx;
                found = slv_req[m_lidx];
            end else begin
                for (int k = 0; k < N; k++) begin
                    int cand;
                    cand = (m_ptr + k) % N;
                    if (!found && slv_req[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
            end
            e_req = found && (q.size() < MAX);
            e_gnt = '0;
            if (e_req && mst_gnt) e_gnt[sel] = 1'b1;
            e_rv    = '0;
            e_rdata = '0;
            if (mst_rvalid && q.size() > 0) begin
                e_rv[q[0]]    = 1'b1;
                e_rdata[q[0]] = mst_rdata;
            end

            @(negedge clk);
            chk("rnd.mst_req", mst_req, e_req);
            chk("rnd.slv_gnt", slv_gnt, e_gnt);
            chk("rnd.slv_rvalid", slv_rvalid, e_rv);
            chk("rnd.slv_rdata", slv_rdata, e_rdata);
            if (e_req) begin
                chk("rnd.mst_addr", mst_addr, slv_addr[sel]);
                chk("rnd.mst_wdata", mst_wdata, slv_wdata[sel]);
                chk("rnd.mst_we", mst_we, slv_we[sel]);
                chk("rnd.mst_be", mst_be, slv_be[sel]);
            end

            if (mst_rvalid && q.size() > 0) void'(q.pop_front());
            if (e_req && mst_gnt) begin
                q.push_back(sel);
`ifndef ADAM_OBI_ARBITER_FIXED_PRIO_EN
                m_ptr = (sel + 1) % N;
`endif
                m_lock = 1'b0;
            end else if (e_req) begin
                m_lock = 1'b1;
                m_lidx = sel;
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
